// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

  localparam int unsigned MIN_DIV = 2;

  // Divide-by-0 and divide-by-1 are meaningless, so clamp to the smallest legal ratio.
  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    return (v < 32'(MIN_DIV)) ? 32'(MIN_DIV) : v;
  endfunction

endpackage

// File: rtl/clk_div_neg_stretch.sv
// Negedge half-cycle stretcher; present only with CLK_DIV_ODD_DUTY50_EN defined.
`ifdef CLK_DIV_ODD_DUTY50_EN
module clk_div_neg_stretch (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic pos_q,
  input  logic odd,
  output logic clk_out
);

  logic neg_q;

  always_ff @(negedge sys_clk or posedge sys_rst) begin
    if (sys_rst) neg_q <= 1'b0;
    else         neg_q <= pos_q;
  end

  // Extending the high phase by half a cycle gives an exact 50% duty for odd ratios.
  assign clk_out = pos_q | (odd & neg_q);

endmodule
`endif

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with period tick and boundary-aligned updates.
// Optional exact 50% duty for odd ratios: define CLK_DIV_ODD_DUTY50_EN.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 6
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] div_active
);

  state_t           state;
  logic [DIV_W-1:0] cnt, cnt_nxt, pend_val, load_val, half;
  logic             pend_vld, wrap, pos_q;

  assign load_val = DIV_W'(clamp_div(32'(div_val)));
  assign half     = div_active >> 1;
  assign wrap     = (state != IDLE) && (cnt == div_active - 1'b1);
  assign tick     = wrap;
  assign cnt_nxt  = wrap ? '0 : cnt + 1'b1;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pos_q      <= 1'b0;
      div_active <= DIV_W'(DEF_DIV);
      pend_val   <= '0;
      pend_vld   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (div_load) div_active <= load_val;
          if (en) begin
            state <= RUN;
            pos_q <= 1'b1;
          end else begin
            pos_q <= 1'b0;
          end
        end
        default: begin
          cnt   <= cnt_nxt;
          pos_q <= (cnt_nxt < half);
          // Ratio changes only land on the wrap, so no period is ever cut short.
          if (wrap) begin
            if (div_load)      div_active <= load_val;
            else if (pend_vld) div_active <= pend_val;
            pend_vld <= 1'b0;
          end else if (div_load) begin
            pend_val <= load_val;
            pend_vld <= 1'b1;
          end
          if (en) begin
            state <= RUN;
          end else if (wrap) begin
            state <= IDLE;
            pos_q <= 1'b0;
            cnt   <= '0;
          end else begin
            state <= STOP;
          end
        end
      endcase
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  clk_div_neg_stretch u_stretch (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .pos_q   (pos_q),
    .odd     (div_active[0]),
    .clk_out (clk_out)
  );
`else
  assign clk_out = pos_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: driver queues per-cycle expectations, monitor checks them.
module tb_clk_div_prog;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       en = 1'b0;
  logic       div_load = 1'b0;
  logic [7:0] div_val = '0;
  logic       clk_out, tick;
  logic [7:0] div_active;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  typedef struct {
    logic       co;
    logic       tk;
    logic [7:0] da;
    string      nm;
  } exp_t;

  exp_t sb[$];

  clk_div_prog #(.DIV_W(8), .DEF_DIV(6)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .en         (en),
    .div_load   (div_load),
    .div_val    (div_val),
    .clk_out    (clk_out),
    .tick       (tick),
    .div_active (div_active)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Monitor: every sampled cycle that has an expectation queued is compared.
  always @(posedge sys_clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp({e.nm, ".clk_out"},    {7'd0, clk_out}, {7'd0, e.co});
      cmp({e.nm, ".tick"},       {7'd0, tick},    {7'd0, e.tk});
      cmp({e.nm, ".div_active"}, div_active,      e.da);
    end
  end

  // Drive one cycle's inputs and queue what the outputs must be after the next edge.
  task automatic cyc(input logic e, input logic ld, input logic [7:0] v,
                     input logic ec, input logic et, input logic [7:0] ed, input string nm);
    exp_t x;
    @(negedge sys_clk);
    en = e; div_load = ld; div_val = v;
    cyc_n++;
    x.co = ec; x.tk = et; x.da = ed; x.nm = $sformatf("%s@%0d", nm, cyc_n);
    sb.push_back(x);
  endtask

  task automatic seq(input logic e, input string pc, input string pt,
                     input logic [7:0] ed, input string nm);
    for (int i = 0; i < pc.len(); i++)
      cyc(e, 1'b0, 8'd0, pc[i] == 8'h31, pt[i] == 8'h31, ed, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge sys_clk);
    #2;
    cmp("rst.clk_out", {7'd0, clk_out}, 8'd0);
    cmp("rst.tick", {7'd0, tick}, 8'd0);
    cmp("rst.div_active", div_active, 8'd6);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd6, "idle");

    // Default ratio 6: 3 high / 3 low, tick on the last low cycle.
    seq(1'b1, "111000111000", "000001000001", 8'd6, "n6");
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd6, "stop_on_wrap");
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd6, "idle2");

    // en dropped at cnt=1: period completes, then idle.
    seq(1'b1, "11", "00", 8'd6, "drop_a");
    seq(1'b0, "100000", "000100", 8'd6, "drop_b");

    // Re-assert en at cnt=3 during the draining period: no interruption.
    seq(1'b1, "11", "00", 8'd6, "rearm_a");
    seq(1'b0, "10", "00", 8'd6, "rearm_b");
    seq(1'b1, "0011", "0100", 8'd6, "rearm_c");
    seq(1'b0, "100000", "000100", 8'd6, "rearm_d");

    // Load 5 in IDLE: takes effect on the next edge.
    cyc(1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 8'd5, "ld5_idle");
`ifdef CLK_DIV_ODD_DUTY50_EN
    seq(1'b1, "1110011100", "0000100001", 8'd5, "n5");
`else
    seq(1'b1, "1100011000", "0000100001", 8'd5, "n5");
`endif

    // Load on the wrap cycle itself: new ratio applies at that wrap.
    cyc(1'b1, 1'b1, 8'd6, 1'b1, 1'b0, 8'd6, "ld6_wrap");
    seq(1'b1, "11", "00", 8'd6, "n6b");
    // Load 4 at cnt=2: current period still finishes at 6.
    cyc(1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 8'd6, "ld4_mid");
    seq(1'b1, "00", "01", 8'd6, "n6_tail");
    seq(1'b1, "11001100", "00010001", 8'd4, "n4");
    seq(1'b1, "1", "0", 8'd4, "n4b");

    // Two pending loads before the boundary: the last (1 -> clamped 2) wins.
    cyc(1'b1, 1'b1, 8'd9, 1'b1, 1'b0, 8'd4, "ld9_pend");
    cyc(1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 8'd4, "ld1_pend");
    seq(1'b1, "0", "1", 8'd4, "n4_tail");
    seq(1'b1, "1010", "0101", 8'd2, "n2");
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, "n2_stop");

    // Clamp in IDLE.
    cyc(1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 8'd9, "ld9_idle");
    cyc(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd2, "ld0_clamp");
    cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd2, "n2_start");

    // Async reset mid-high: outputs drop without a clock edge.
    @(posedge sys_clk);
    #2;
    sys_rst = 1'b1;
    #1;
    cmp("async_rst.clk_out", {7'd0, clk_out}, 8'd0);
    cmp("async_rst.tick", {7'd0, tick}, 8'd0);
    cmp("async_rst.div_active", div_active, 8'd6);
    en = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd6, "post_rst");
    seq(1'b1, "111000", "000001", 8'd6, "post_rst_n6");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge sys_clk);
    #3;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider; successor to the fixed divide-by-six block.
- Generates a divided clock `clk_out` from `sys_clk` for ratios 2..2^DIV_W-1, plus a one-cycle period strobe `tick`.
- Supports glitch-free ratio change and graceful enable/disable, both applied only at period boundaries.
- Feeds local slow-clock / clock-enable consumers in the same clock domain.

Parameters:
- DIV_W, 8, width of divisor input and internal counter.
- DEF_DIV, 6, active divisor after reset; must be >= 2 and < 2^DIV_W.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge (see Optional Feature for the one exception).
- sys_rst  in  1  reset, asynchronous, active-high.
- en  in  1  run request.
- div_load  in  1  one-cycle pulse; captures div_val.
- div_val  in  DIV_W  requested divisor N.
- clk_out  out  1  divided clock, registered.
- tick  out  1  high in the last sys_clk cycle of each output period.
- div_active  out  DIV_W  divisor currently in use.

Behaviour:
- Reset (async, sys_rst=1) forces:
  - state=IDLE, cnt=0, clk_out=0, tick=0.
  - div_active=DEF_DIV; pending divisor cleared.
- Divisor clamp: a captured value below 2 is stored as 2.
- High time: H = div_active>>1 (floor).
- States: IDLE, RUN, STOP (STOP means en was dropped mid-period).
- IDLE:
  - cnt=0, clk_out=0.
  - On a sampled en=1: go to RUN, cnt stays 0, clk_out<=1. clk_out is therefore high one clock after en rises.
- RUN:
  - Next count: cnt_nxt = (cnt==N-1) ? 0 : cnt+1.
  - clk_out <= (cnt_nxt < H).
  - Result: high H cycles, low N-H cycles, period exactly N.
  - Wrap = cycle with cnt==N-1.
  - en=0 sampled before the wrap: go to STOP.
  - en=0 sampled on the wrap cycle: go to IDLE, clk_out<=0.
- STOP:
  - Counts exactly as RUN.
  - en=1 again: return to RUN; no period disturbance.
  - At wrap: go to IDLE, clk_out<=0. A partial period is never emitted.
- tick:
  - tick = (state!=IDLE) && (cnt==div_active-1).
  - Decoded from registers only; no combinational path from any input.
- Divisor update:
  - div_load in IDLE: div_active updates on the next edge.
  - div_load in RUN/STOP: value held as pending; pending becomes div_active at the next wrap.
  - div_load on the same cycle as a wrap: new value takes effect at that wrap.
  - Multiple loads before a boundary: the last one wins.
- No clk_out glitch or runt pulse under any load or en sequence.
- Reset mid-run: outputs drop immediately; restart from IDLE after release.

Optional Feature:
- Macro: CLK_DIV_ODD_DUTY50_EN.
- Defined:
  - Negedge flop neg_q samples the posedge clk_out.
  - For odd div_active: clk_out_final = pos_q | neg_q, giving high time N/2 cycles exactly (e.g. 2.5 of 5).
  - For even N: neg_q is ignored.
  - neg_q is reset to 0.
- Not defined:
  - Odd N gives floor(N/2) high, ceil(N/2) low.
  - No negedge logic present.

Decomposition:
- clk_div_pkg contains:
  - state enum (IDLE/RUN/STOP).
  - MIN_DIV=2.
  - Clamp function for the divisor.
- One natural sub-module: clk_div_neg_stretch, the negedge half-cycle stretcher. Instantiated only under CLK_DIV_ODD_DUTY50_EN.

Test Plan:
- Reset release, en=1, no load -> div_active=6; clk_out 3 high / 3 low; tick every 6th cycle, coincident with the last low cycle.
- div_load=5 in IDLE, en=1 -> without macro: 2 high / 3 low; with macro: high 2.5 cycles, low 2.5 cycles, period 5.
- N=6 running, div_load=4 at cnt=2 -> current period completes at 6 cycles; next periods 2 high / 2 low; div_active changes exactly at the wrap.
- div_load=0 then div_load=1 -> div_active=2; clk_out toggles every sys_clk; tick every 2nd cycle.
- N=6, en dropped at cnt=1 -> period completes; tick once at cnt=5; then clk_out stays 0, state IDLE; re-assert en at cnt=3 in a repeat run -> no interruption.
- sys_rst pulsed mid-high phase -> clk_out, tick go 0 without waiting for a clock edge; div_active=6 after release.
